// File: rtl/rom_cmd_fetcher.sv
// Walks the lookup ROM from BASE_ADDR, packs WORDS_PER_CMD words per drawing command and
// presents each command over valid/ready; a zero leading word or the ROM end stops the walk.
module rom_cmd_fetcher #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int WORDS_PER_CMD = 2,
  parameter int BASE_ADDR     = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  input  logic [DATA_WIDTH-1:0]               rom_data,
  output logic                                cmd_valid,
  input  logic                                cmd_ready,
  output logic [WORDS_PER_CMD*DATA_WIDTH-1:0] cmd_data,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;

  localparam int                    IDX_W    = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS_PER_CMD - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_END = '1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             last_at_end;  // final word of the presented command came from ADDR_END

  assign busy = (state != IDLE);

  // NOTE: every register here uses non-blocking assignment so all next-state values are
  // computed from the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr    <= BASE;
      idx         <= '0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      last_at_end <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cmd_valid <= 1'b0;
        idx       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              rom_addr <= BASE;
              idx      <= '0;
              state    <= FETCH;
            end
          end
          FETCH: begin
            if (idx == '0 && rom_data == '0) begin
              // Terminator: address is left pointing at the zero word.
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cmd_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= rom_data;
              if (rom_addr != ADDR_END) rom_addr <= rom_addr + 1'b1;
              if (idx == LAST_IDX) begin
                cmd_valid   <= 1'b1;
                idx         <= '0;
                last_at_end <= (rom_addr == ADDR_END);
                state       <= PRESENT;
              end else if (rom_addr == ADDR_END) begin
                // ROM exhausted mid-command: drop the partial words.
                cmd_data <= '0;
                idx      <= '0;
                err      <= 1'b1;
                state    <= IDLE;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          PRESENT: begin
            if (cmd_valid && cmd_ready) begin
              cmd_valid <= 1'b0;
              if (last_at_end) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                state <= FETCH;
              end
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_cmd_fetcher.sv
// Directed bench for rom_cmd_fetcher: four instances cover W=2/W=4 from address 0 and
// W=2/W=1 from the all-ones address, each fed by its own behavioural ROM.
module tb_rom_cmd_fetcher;

  logic clk = 1'b0;
  logic rst_n, abort, cmd_ready;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_list(input logic [7:0] a);
    case (a)
      8'd0: return 32'd1;
      8'd1: return 32'd2;
      8'd2: return 32'd30;
      8'd3: return 32'd40;
      8'd4: return 32'd45;
      8'd5: return 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rom_top(input logic [7:0] a);
    return (a == 8'hFF) ? 32'd7 : 32'd0;
  endfunction

  // a: W=2 base 0, b: W=4 base 0, c: W=2 base FF, d: W=1 base FF
  logic         a_start, b_start, c_start, d_start;
  logic [7:0]   a_addr, b_addr, c_addr, d_addr;
  logic [31:0]  a_rd, b_rd, c_rd, d_rd;
  logic         a_valid, b_valid, c_valid, d_valid;
  logic [63:0]  a_data, c_data;
  logic [127:0] b_data;
  logic [31:0]  d_data;
  logic         a_busy, b_busy, c_busy, d_busy;
  logic         a_done, b_done, c_done, d_done;
  logic         a_err, b_err, c_err, d_err;

  assign a_rd = rom_list(a_addr);
  assign b_rd = rom_list(b_addr);
  assign c_rd = rom_top(c_addr);
  assign d_rd = rom_top(d_addr);

  rom_cmd_fetcher #(.WORDS_PER_CMD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(abort), .rom_addr(a_addr),
    .rom_data(a_rd), .cmd_valid(a_valid), .cmd_ready(cmd_ready), .cmd_data(a_data),
    .busy(a_busy), .done(a_done), .err(a_err));

  rom_cmd_fetcher #(.WORDS_PER_CMD(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(abort), .rom_addr(b_addr),
    .rom_data(b_rd), .cmd_valid(b_valid), .cmd_ready(cmd_ready), .cmd_data(b_data),
    .busy(b_busy), .done(b_done), .err(b_err));

  rom_cmd_fetcher #(.WORDS_PER_CMD(2), .BASE_ADDR(8'hFF)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .abort(abort), .rom_addr(c_addr),
    .rom_data(c_rd), .cmd_valid(c_valid), .cmd_ready(cmd_ready), .cmd_data(c_data),
    .busy(c_busy), .done(c_done), .err(c_err));

  rom_cmd_fetcher #(.WORDS_PER_CMD(1), .BASE_ADDR(8'hFF)) u_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .abort(abort), .rom_addr(d_addr),
    .rom_data(d_rd), .cmd_valid(d_valid), .cmd_ready(cmd_ready), .cmd_data(d_data),
    .busy(d_busy), .done(d_done), .err(d_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return a_valid;
      1: return a_done;
      2: return b_valid;
      3: return b_done;
      4: return c_err;
      5: return d_valid;
      default: return 1'b0;
    endcase
  endfunction

  // Ticks until the selected signal is high; returns the number of edges waited.
  task automatic wait_sig(input string tag, input int which, input int budget, output int n);
    n = 0;
    while (!sig(which) && n < budget) begin
      tick();
      n++;
    end
    if (!sig(which)) check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic pulse_start(input int which);
    case (which)
      0: a_start = 1'b1;
      1: b_start = 1'b1;
      2: c_start = 1'b1;
      default: d_start = 1'b1;
    endcase
    tick();
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; d_start = 1'b0;
  endtask

  int n;
  logic seen;

  initial begin
    rst_n = 1'b0; abort = 1'b0; cmd_ready = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; d_start = 1'b0;
    #12;
    check("rst_addr_a", a_addr, 8'h00);
    check("rst_addr_c", c_addr, 8'hFF);
    check("rst_out_a", {a_valid, a_busy, a_done, a_err, a_data}, '0);
    rst_n = 1'b1;
    tick();

    // Full walk, W=2, ready held high
    pulse_start(0);
    check("busy_after_start", a_busy, 1'b1);
    wait_sig("cmd1", 0, 4, n);
    check("latency_w2", n, 2);
    check("cmd1", a_data, 64'h00000002_00000001);
    tick();
    wait_sig("cmd2", 0, 4, n);
    check("cmd2", a_data, 64'h00000028_0000001E);
    tick();
    wait_sig("cmd3", 0, 4, n);
    check("cmd3", a_data, 64'h00000003_0000002D);
    tick();
    wait_sig("done_a", 1, 4, n);
    check("done_addr", a_addr, 8'd6);
    check("done_idle", a_busy, 1'b0);
    check("done_err_excl", a_err, 1'b0);
    tick();
    check("done_pulse_1cyc", a_done, 1'b0);

    // Backpressure: ready low for 10 cycles after first valid
    cmd_ready = 1'b0;
    pulse_start(0);
    wait_sig("bp_cmd1", 0, 4, n);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", a_valid, 1'b1);
      check("bp_data", a_data, 64'h00000002_00000001);
      check("bp_addr", a_addr, 8'd2);
    end
    cmd_ready = 1'b1;
    tick();
    check("bp_release", a_valid, 1'b0);

    // Abort while presenting the second command, then restart from the base
    cmd_ready = 1'b0;
    wait_sig("ab_cmd2", 0, 4, n);
    check("ab_cmd2", a_data, 64'h00000028_0000001E);
    abort = 1'b1;
    a_start = 1'b1;  // abort beats start
    tick();
    abort = 1'b0;
    a_start = 1'b0;
    check("ab_valid", a_valid, 1'b0);
    check("ab_busy", a_busy, 1'b0);
    check("ab_nodone", a_done, 1'b0);
    tick();
    check("ab_still_idle", a_busy, 1'b0);
    pulse_start(0);
    check("ab_restart_addr", a_addr, 8'd0);
    wait_sig("ab_recmd", 0, 4, n);
    check("ab_recmd", a_data, 64'h00000002_00000001);
    pulse_start(0);  // start while busy is ignored
    check("start_ignored", {a_valid, a_addr}, {1'b1, 8'd2});
    cmd_ready = 1'b1;

    // W=4: slot 2/3 zeros captured inside a command, lead zero ends the list
    pulse_start(1);
    wait_sig("w4_cmd1", 2, 6, n);
    check("latency_w4", n, 4);
    check("w4_cmd1", b_data, 128'h00000028_0000001E_00000002_00000001);
    tick();
    wait_sig("w4_cmd2", 2, 6, n);
    check("w4_cmd2", b_data, 128'h00000000_00000000_00000003_0000002D);
    tick();
    wait_sig("w4_done", 3, 6, n);
    check("w4_done_addr", b_addr, 8'd8);

    // W=2 from the all-ones address: ROM end mid-command
    seen = 1'b0;
    pulse_start(2);
    for (int i = 0; i < 4 && !c_err; i++) begin
      seen |= c_valid;
      tick();
    end
    check("end_err", c_err, 1'b1);
    check("end_no_valid", seen | c_valid, 1'b0);
    check("end_no_done", c_done, 1'b0);
    tick();
    check("end_err_1cyc", {c_err, c_busy}, 2'b00);

    // W=1 from the all-ones address: one command, then done with no wrap
    pulse_start(3);
    wait_sig("w1_cmd", 5, 3, n);
    check("w1_cmd", d_data, 32'd7);
    check("w1_addr_nowrap", d_addr, 8'hFF);
    tick();
    check("w1_done", {d_done, d_valid, d_err}, 3'b100);
    tick();
    check("w1_done_1cyc", {d_done, d_busy}, 2'b00);

    // Asynchronous reset mid-fetch
    pulse_start(0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", a_addr, 8'd0);
    check("arst_out", {a_valid, a_busy, a_done, a_err, a_data}, '0);
    #3 rst_n = 1'b1;
    tick();
    check("arst_idle", a_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
